// File: rtl/csr_file_unit.sv
// Machine-mode CSR file: combinational raw reads for decode masking, trap/MRET side effects, mcycle/minstret.
// Latency: reads are 0-cycle with no write bypass, and updates appear after the next edge. There is no backpressure: every request is accepted.
module csr_file_unit #(
  parameter int XLEN = 2,  // width code: 1 -> 32b, 2 -> 64b
  localparam int W = 1 << (XLEN + 4),
  parameter logic [W-1:0] RESET_MTVEC = '0,
  parameter logic [W-1:0] MISA_VALUE = {XLEN[1:0], {(W - 28){1'b0}}, 26'h0001100}
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [11:0]  i_csr_raddr,
  output logic [W-1:0] o_old_csr,
  output logic         o_illegal_csr,
  input  logic         i_csr_rd_valid,
  input  logic         i_csr_we,
  input  logic [11:0]  i_csr_waddr,
  input  logic [W-1:0] i_masked_new_csr,
  input  logic         i_trap,
  input  logic [W-1:0] i_trap_pc,
  input  logic [W-1:0] i_trap_cause,
  input  logic [W-1:0] i_trap_tval,
  input  logic         i_mret,
  input  logic         i_instr_retired,
  output logic [W-1:0] o_trap_vector,
  output logic [W-1:0] o_mepc,
  output logic         o_mie_global
);

  localparam bit IS_RV32 = (W == 32);

  logic         mst_mie, mst_mpie;
  logic [W-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]  mcycle_q, minstret_q, mcycle_n, minstret_n, wdata64;
  logic [W-1:0] mstatus_val, rdata, tvec_base;
  logic         legal, csr_wr;

  // Only M-mode exists, so MPP is hardwired to 2'b11.
  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mst_mpie;
    mstatus_val[3]     = mst_mie;
  end

  always_comb begin
    rdata = '0;
    legal = 1'b1;
    case (i_csr_raddr)
      12'h300: rdata = mstatus_val;
      12'h301: rdata = MISA_VALUE;
      12'h304: rdata = mie_q;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'h344: rdata = '0;
      12'hB00: rdata = mcycle_q[W-1:0];
      12'hB02: rdata = minstret_q[W-1:0];
      12'hF14: rdata = '0;
      12'hB80: if (IS_RV32) rdata = W'(mcycle_q[63:32]); else legal = 1'b0;
      12'hB82: if (IS_RV32) rdata = W'(minstret_q[63:32]); else legal = 1'b0;
      default: legal = 1'b0;
    endcase
  end

  assign o_old_csr     = rdata;
  assign o_illegal_csr = i_csr_rd_valid & ~legal;

  // Trap and MRET own the cycle; a coincident CSR write is dropped.
  assign csr_wr  = i_csr_we & ~i_trap & ~i_mret;
  assign wdata64 = 64'(i_masked_new_csr);

  always_comb begin
    mcycle_n   = mcycle_q + 64'd1;
    minstret_n = minstret_q + {63'd0, i_instr_retired};
    if (csr_wr && i_csr_waddr == 12'hB00)
      mcycle_n = IS_RV32 ? {mcycle_q[63:32], wdata64[31:0]} : wdata64;
    else if (csr_wr && IS_RV32 && i_csr_waddr == 12'hB80)
      mcycle_n = {wdata64[31:0], mcycle_q[31:0]};
    if (csr_wr && i_csr_waddr == 12'hB02)
      minstret_n = IS_RV32 ? {minstret_q[63:32], wdata64[31:0]} : wdata64;
    else if (csr_wr && IS_RV32 && i_csr_waddr == 12'hB82)
      minstret_n = {wdata64[31:0], minstret_q[31:0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= {RESET_MTVEC[W-1:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_n;
      minstret_q <= minstret_n;
      if (i_trap) begin
        mepc_q   <= {i_trap_pc[W-1:2], 2'b00};
        mcause_q <= i_trap_cause;
        mtval_q  <= i_trap_tval;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (i_mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (csr_wr) begin
        case (i_csr_waddr)
          12'h300: begin
            mst_mie  <= i_masked_new_csr[3];
            mst_mpie <= i_masked_new_csr[7];
          end
          12'h304: mie_q      <= i_masked_new_csr;
          12'h305: mtvec_q    <= i_masked_new_csr;
          12'h340: mscratch_q <= i_masked_new_csr;
          12'h341: mepc_q     <= {i_masked_new_csr[W-1:2], 2'b00};
          12'h342: mcause_q   <= i_masked_new_csr;
          12'h343: mtval_q    <= i_masked_new_csr;
          default: ;
        endcase
      end
    end
  end

  // Vectored mode only redirects interrupts; the shift drops cause bit W-2 (mod 2^W).
  assign tvec_base = {mtvec_q[W-1:2], 2'b00};
  always_comb begin
    o_trap_vector = tvec_base;
    if (mtvec_q[1:0] == 2'b01 && i_trap_cause[W-1])
      o_trap_vector = tvec_base + W'({i_trap_cause[W-2:0], 2'b00});
  end

  assign o_mepc       = mepc_q;
  assign o_mie_global = mst_mie;

endmodule

// File: tb/tb_csr_file_unit.sv
// Directed self-checking bench for csr_file_unit (64-bit configuration).
module tb_csr_file_unit;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  raddr, waddr;
  logic [W-1:0] old_csr, wdata, trap_pc, trap_cause, trap_tval, trap_vector, mepc;
  logic         illegal, rd_valid, we, trap, mret, retired, mie_global;

  int passed = 0;
  int total  = 0;

  csr_file_unit #(.XLEN(2), .RESET_MTVEC(64'h8000_0100)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_csr_raddr(raddr), .o_old_csr(old_csr), .o_illegal_csr(illegal),
    .i_csr_rd_valid(rd_valid), .i_csr_we(we), .i_csr_waddr(waddr),
    .i_masked_new_csr(wdata), .i_trap(trap), .i_trap_pc(trap_pc),
    .i_trap_cause(trap_cause), .i_trap_tval(trap_tval), .i_mret(mret),
    .i_instr_retired(retired), .o_trap_vector(trap_vector), .o_mepc(mepc),
    .o_mie_global(mie_global)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [63:0] exp);
    raddr = a;
    #1;
    check(tag, old_csr, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; raddr = '0; rd_valid = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    trap = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0; mret = 1'b0; retired = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    rd_valid = 1'b1;
    rd(12'h305, "mtvec_reset", 64'h8000_0100);
    check("mtvec_legal", {63'd0, illegal}, 64'd0);
    rd(12'h300, "mstatus_reset", 64'h1800);
    check("mie_reset", {63'd0, mie_global}, 64'd0);
    rd(12'hB00, "mcycle_reset", 64'd0);
    rd(12'h7C0, "unimpl_read", 64'd0);
    check("unimpl_illegal", {63'd0, illegal}, 64'd1);
    rd(12'hB80, "mcycleh_rd", 64'd0);
    check("mcycleh_illegal_64", {63'd0, illegal}, 64'd1);
    rd_valid = 1'b0;
    #1;
    check("illegal_qualified", {63'd0, illegal}, 64'd0);
    rd(12'h301, "misa", 64'h8000_0000_0000_1100);
    tick();
    rd(12'hB00, "mcycle_first", 64'd1);

    // mepc write, no bypass on same-cycle read
    we = 1'b1; waddr = 12'h341; wdata = 64'h1003;
    rd(12'h341, "mepc_no_bypass", 64'd0);
    tick(); we = 1'b0;
    check("mepc_aligned", mepc, 64'h1000);

    // Trap with MIE set and a coincident mscratch write
    wr(12'h300, 64'h8);
    check("mie_set", {63'd0, mie_global}, 64'd1);
    rd(12'h300, "mstatus_w", 64'h1808);
    wr(12'h340, 64'h55);
    trap = 1'b1; trap_pc = 64'h2004; trap_cause = 64'd2; trap_tval = 64'hDEAD;
    we = 1'b1; waddr = 12'h340; wdata = 64'h77;
    tick();
    trap = 1'b0; we = 1'b0;
    check("trap_mepc", mepc, 64'h2004);
    rd(12'h342, "trap_mcause", 64'd2);
    rd(12'h343, "trap_mtval", 64'hDEAD);
    rd(12'h300, "trap_mstatus", 64'h1880);
    check("trap_mie", {63'd0, mie_global}, 64'd0);
    rd(12'h340, "mscratch_dropped", 64'h55);

    // MRET
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd(12'h300, "mret_mstatus", 64'h1888);
    check("mret_mie", {63'd0, mie_global}, 64'd1);

    // Trap vector modes
    wr(12'h305, 64'h1001);
    trap_cause = (64'd1 << 63) | 64'd7;
    #1;
    check("tvec_vectored", trap_vector, 64'h101C);
    trap_cause = 64'd7;
    #1;
    check("tvec_sync", trap_vector, 64'h1000);

    // Read-only CSRs ignore writes
    wr(12'h301, 64'h0);
    rd(12'h301, "misa_ro", 64'h8000_0000_0000_1100);
    wr(12'h344, 64'hFF);
    rd(12'h344, "mip_zero", 64'd0);

    // Counter wrap
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00, "mcycle_written", 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd(12'hB00, "mcycle_wrap", 64'd0);

    // minstret
    rd(12'hB02, "minstret_idle", 64'd0);
    retired = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    retired = 1'b0;
    rd(12'hB02, "minstret_5", 64'd5);

    // Reset mid-run dominates a coincident trap
    rst = 1'b1; trap = 1'b1; trap_pc = 64'h4444;
    tick();
    rst = 1'b0; trap = 1'b0;
    rd(12'hB00, "mcycle_rst", 64'd0);
    rd(12'hB02, "minstret_rst", 64'd0);
    check("mepc_rst", mepc, 64'd0);
    rd(12'h305, "mtvec_rst", 64'h8000_0100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
